router_port_receiver: RTL and testbench

Downstream stage for one router output port. Consumes the serial dout/valido_n/frameo_n stream for a single port and assembles it into bytes, LSB first. Buffers the bytes, with an end-of-packet marker, in a show-ahead FIFO. A host-side consumer drains the FIFO through a valid/ready interface; sixteen instances cover the full router.

---
 rtl/router_port_receiver.sv | 160 ++++++++++++++++
 tb/tb_router_port_receiver.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/router_port_receiver.sv
// Router output-port receiver: deserialises the dout/valido_n/frameo_n
// stream LSB first and buffers bytes plus an end-of-packet flag in a
// show-ahead FIFO drained through a valid/ready interface.
// Optional feature macro: RCV_PKT_CNT_EN (adds pkt_count output).
module router_port_receiver #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       dout,
  input  logic       valido_n,
  input  logic       frameo_n,
  input  logic       rd_ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       rd_last,
  output logic       busy,
  output logic       frag_err,
  output logic       overflow
`ifdef RCV_PKT_CNT_EN
  ,
  output logic [15:0] pkt_count
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

  state_t          state, state_nxt;
  logic [2:0]      bit_cnt, bit_cnt_nxt;
  logic [7:0]      shift, shift_nxt, shift_set;
  logic            wr_req, wr_last, frag_nxt;

  logic [8:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic            full, pop, wr_en;
  logic [8:0]      wr_entry, head;

  // Shift register with the current bit merged in at its position
  always_comb begin
    shift_set          = shift;
    shift_set[bit_cnt] = dout;
  end

  // Next-state and byte-completion decode
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    wr_req      = 1'b0;
    wr_last     = 1'b0;
    frag_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (!frameo_n) begin
          state_nxt   = RECV;
          bit_cnt_nxt = 3'd0;
          if (!valido_n) begin
            shift_nxt   = shift_set;
            bit_cnt_nxt = 3'd1;
          end
        end
      end
      RECV: begin
        if (!valido_n) begin
          shift_nxt   = shift_set;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            wr_req  = 1'b1;
            wr_last = frameo_n;
            // A dropped final byte already ends the frame, so skip DISCARD
            if (full) state_nxt = frameo_n ? IDLE : DISCARD;
            else if (frameo_n) state_nxt = IDLE;
          end else if (frameo_n) begin
            frag_nxt    = 1'b1;
            state_nxt   = IDLE;
            bit_cnt_nxt = 3'd0;
          end
        end else if (frameo_n) begin
          frag_nxt    = 1'b1;
          state_nxt   = IDLE;
          bit_cnt_nxt = 3'd0;
        end
      end
      DISCARD: begin
        if (frameo_n) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO control; full is judged before any same-cycle pop
  always_comb begin
    full       = (count == CW'(FIFO_DEPTH));
    pop        = rd_valid & rd_ready;
    wr_en      = wr_req & ~full;
    wr_entry   = {wr_last, shift_set};
    count_nxt  = count + CW'(wr_en) - CW'(pop);
    rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
    head       = mem[rd_ptr_nxt];
    if (wr_en && (rd_ptr_nxt == wr_ptr)) head = wr_entry;
  end

  // Receiver state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      shift    <= 8'd0;
      busy     <= 1'b0;
      frag_err <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shift    <= shift_nxt;
      busy     <= (state_nxt != IDLE);
      frag_err <= frag_nxt;
      overflow <= overflow | (wr_req & full);
    end
  end

  // FIFO storage; contents are only observed through valid pointers
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

  // FIFO pointers and registered show-ahead head (held while empty)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= 8'd0;
      rd_last  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      rd_valid <= (count_nxt != '0);
      if (count_nxt != '0) begin
        rd_last <= head[8];
        rd_data <= head[7:0];
      end
    end
  end

`ifdef RCV_PKT_CNT_EN
  // Completed packets actually stored in the FIFO
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pkt_count <= 16'd0;
    else if (wr_en && wr_last) pkt_count <= pkt_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_router_port_receiver.sv
// Self-checking bench for router_port_receiver with a queue-based model.
module tb_router_port_receiver;
  localparam int unsigned DEPTH = 4;

  logic clock = 1'b0;
  logic reset_n, dout, valido_n, frameo_n, rd_ready;
  logic rd_valid, rd_last, busy, frag_err, overflow;
  logic [7:0] rd_data;
`ifdef RCV_PKT_CNT_EN
  logic [15:0] pkt_count;
`endif

  always #5 clock = ~clock;

  router_port_receiver #(.FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .dout(dout), .valido_n(valido_n),
    .frameo_n(frameo_n), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_last(rd_last), .busy(busy),
    .frag_err(frag_err), .overflow(overflow)
`ifdef RCV_PKT_CNT_EN
    , .pkt_count(pkt_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {logic [7:0] d; logic l;} ent_t;
  ent_t        q[$];
  logic        bits[$];
  int          mode;        // 0 outside a packet, 1 collecting, 2 dropping rest
  logic        m_frag, m_ovf, m_last;
  logic [7:0]  m_data;
  logic [15:0] m_cnt;
  bit          was_full, do_pop, v, f;
  logic [7:0]  b;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q.delete(); bits.delete();
      mode = 0; m_frag = 0; m_ovf = 0; m_data = 0; m_last = 0; m_cnt = 0;
    end else begin
      v = !valido_n; f = !frameo_n;
      was_full = (q.size() == DEPTH);
      do_pop = rd_ready && (q.size() > 0);
      m_frag = 0;
      if (do_pop) void'(q.pop_front());
      case (mode)
        0: if (f) begin
             mode = 1; bits.delete();
             if (v) bits.push_back(dout);
           end
        1: begin
             if (v) begin
               bits.push_back(dout);
               if (bits.size() == 8) begin
                 for (int i = 0; i < 8; i++) b[i] = bits[i];
                 bits.delete();
                 if (was_full) begin
                   m_ovf = 1;
                   mode = f ? 2 : 0;
                 end else begin
                   q.push_back('{d: b, l: !f});
                   if (!f) m_cnt = m_cnt + 16'd1;
                   if (!f) mode = 0;
                 end
               end else if (!f) begin
                 m_frag = 1; mode = 0;
               end
             end else if (!f) begin
               m_frag = 1; mode = 0;
             end
           end
        default: if (!f) mode = 0;
      endcase
      if (q.size() > 0) begin
        m_data = q[0].d; m_last = q[0].l;
      end
    end
  end

  // Compare DUT against model every cycle, away from the active edge
  always @(negedge clock) begin
    chk("rd_valid", 16'(rd_valid), 16'(q.size() > 0));
    chk("rd_data",  16'(rd_data),  16'(m_data));
    chk("rd_last",  16'(rd_last),  16'(m_last));
    chk("busy",     16'(busy),     16'(mode != 0));
    chk("frag_err", 16'(frag_err), 16'(m_frag));
    chk("overflow", 16'(overflow), 16'(m_ovf));
`ifdef RCV_PKT_CNT_EN
    chk("pkt_count", pkt_count, m_cnt);
`endif
  end

  // ---------------- stimulus ----------------
  bit rnd_ready = 0;
  int ready_pct = 50;

  task automatic step(input logic d, input logic v_n, input logic f_n);
    dout = d; valido_n = v_n; frameo_n = f_n;
    if (rnd_ready) rd_ready = ($urandom_range(0, 99) < 32'(ready_pct));
    @(posedge clock);
    #1;
  endtask

  task automatic send_pkt(input int nbits, input logic [63:0] val, input int gap_at,
                          input int gap_len, input bit rnd_gaps, input bit end_on_gap);
    for (int i = 0; i < nbits; i++) begin
      if (i == gap_at) repeat (gap_len) step(1'b0, 1'b1, 1'b0);
      if (rnd_gaps && $urandom_range(0, 3) == 0) step(1'($urandom), 1'b1, 1'b0);
      step(val[i], 1'b0, (i == nbits - 1) && !end_on_gap);
    end
  endtask

  task automatic do_reset();
    #1 reset_n = 1'b0;
    #1;
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  logic [7:0] a5;
  int nb;

  initial begin
    reset_n = 1'b0; dout = 1'b0; valido_n = 1'b1; frameo_n = 1'b1; rd_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 16'(rd_valid), 16'd0);
    chk("rst_data",  16'(rd_data),  16'd0);
    chk("rst_last",  16'(rd_last),  16'd0);
    chk("rst_busy",  16'(busy),     16'd0);
    chk("rst_frag",  16'(frag_err), 16'd0);
    chk("rst_ovf",   16'(overflow), 16'd0);
    reset_n = 1'b1;
    step(1'b0, 1'b1, 1'b1);

    // Single-byte packet 0xA5
    a5 = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      step(a5[i], 1'b0, i == 7);
      if (i == 3) chk("a5_busy_mid", 16'(busy), 16'd1);
    end
    chk("a5_valid", 16'(rd_valid), 16'd1);
    chk("a5_data",  16'(rd_data),  16'h00A5);
    chk("a5_last",  16'(rd_last),  16'd1);
    chk("a5_busy_after", 16'(busy), 16'd0);
    step(1'b0, 1'b1, 1'b1);
    rd_ready = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    rd_ready = 1'b0;
    chk("a5_drained", 16'(rd_valid), 16'd0);
    chk("a5_hold",    16'(rd_data),  16'h00A5);

    // Two bytes with a 3-cycle gap mid-byte
    send_pkt(16, 64'hF03C, 4, 3, 0, 0);
    chk("two_b0_data", 16'(rd_data), 16'h003C);
    chk("two_b0_last", 16'(rd_last), 16'd0);
    rd_ready = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    chk("two_b1_data", 16'(rd_data), 16'h00F0);
    chk("two_b1_last", 16'(rd_last), 16'd1);
    step(1'b0, 1'b1, 1'b1);
    chk("two_empty", 16'(rd_valid), 16'd0);
    rd_ready = 1'b0;

    // Fragment: 12 bits
    send_pkt(12, 64'h596, -1, 0, 0, 0);
    chk("frag_pulse", 16'(frag_err), 16'd1);
    chk("frag_b0",    16'(rd_data),  16'h0096);
    chk("frag_last",  16'(rd_last),  16'd0);
    step(1'b0, 1'b1, 1'b1);
    chk("frag_one_cycle", 16'(frag_err), 16'd0);
    rd_ready = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    chk("frag_one_entry", 16'(rd_valid), 16'd0);
    rd_ready = 1'b0;

    // Overflow: 6-byte packet into a 4-deep FIFO, then one while still full
    send_pkt(48, 64'h0605_0403_0201, -1, 0, 0, 0);
    step(1'b0, 1'b1, 1'b1);
    chk("ovf_set", 16'(overflow), 16'd1);
    send_pkt(8, 64'h77, -1, 0, 0, 0);
    step(1'b0, 1'b1, 1'b1);
    rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("ovf_entry", 16'(rd_data), 16'(k + 1));
      step(1'b0, 1'b1, 1'b1);
    end
    rd_ready = 1'b0;
    chk("ovf_drained", 16'(rd_valid), 16'd0);
    chk("ovf_sticky",  16'(overflow), 16'd1);
    send_pkt(8, 64'h77, -1, 0, 0, 0);
    chk("ovf_accept_after_space", 16'(rd_data), 16'h0077);
    rd_ready = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    rd_ready = 1'b0;

    // Reset after 5 bits of a byte
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 16'(rd_valid), 16'd0);
    chk("mid_rst_data",  16'(rd_data),  16'd0);
    chk("mid_rst_busy",  16'(busy),     16'd0);
    chk("mid_rst_ovf",   16'(overflow), 16'd0);
    dout = 1'b0; valido_n = 1'b1; frameo_n = 1'b1;
    @(posedge clock);
    #1 reset_n = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    send_pkt(8, 64'h5A, -1, 0, 0, 0);
    chk("post_rst_data", 16'(rd_data), 16'h005A);
    chk("post_rst_last", 16'(rd_last), 16'd1);
    rd_ready = 1'b1;
    step(1'b0, 1'b1, 1'b1);

`ifdef RCV_PKT_CNT_EN
    // Packet counter: 3 good packets plus one fragment
    do_reset();
    rd_ready = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    send_pkt(8,  64'h11,     -1, 0, 0, 0); step(1'b0, 1'b1, 1'b1);
    send_pkt(16, 64'h2233,   -1, 0, 0, 0); step(1'b0, 1'b1, 1'b1);
    send_pkt(24, 64'h445566, -1, 0, 0, 0); step(1'b0, 1'b1, 1'b1);
    send_pkt(10, 64'h3FF,    -1, 0, 0, 0); step(1'b0, 1'b1, 1'b1);
    chk("pkt_count_3", pkt_count, 16'd3);
`endif

    // Randomised packets with random gaps, endings and back-pressure
    rnd_ready = 1;
    for (int p = 0; p < 80; p++) begin
      ready_pct = ($urandom_range(0, 3) == 0) ? 10 : 70;
      nb = ($urandom_range(0, 1) == 0) ? 8 * int'($urandom_range(1, 6)) : int'($urandom_range(2, 40));
      send_pkt(nb, {$urandom, $urandom}, -1, 0, 1, $urandom_range(0, 5) == 0);
      repeat ($urandom_range(1, 3)) step(1'b0, 1'b1, 1'b1);
      if (p == 40) do_reset();
    end
    rnd_ready = 0;
    rd_ready = 1'b1;
    repeat (DEPTH + 2) step(1'b0, 1'b1, 1'b1);
    chk("final_empty", 16'(rd_valid), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
